ds2431_read_scratchpad: RTL and testbench
=========================================

Name: ds2431_read_scratchpad

Overview:
- Responder for the DS2431 "Read Scratchpad" (0xAA) function command in the virtual 1-Wire EEPROM.
- Once the command byte has been decoded upstream, the block streams TA1, TA2 and E/S, then the scratchpad bytes from offset TA1[2:0] to the end of the 8-byte row, then the inverted CRC16, then 0xFF fill.
- Each byte is handed to the 1-Wire byte transceiver through a trigger/done handshake.

Parameters:
- none. Constants live in the package.

Ports:
- clk  in  1  system clock (20 ns in the bench).
- nRst  in  1  asynchronous, active-low reset.
- Scratchpad  in  64  scratchpad row; byte n = Scratchpad[8n+7:8n].
- TA1  in  8  target address low; bits [2:0] give the start offset.
- TA2  in  8  target address high.
- ES  in  8  ending-address/status byte.
- cmdRunTrig  in  1  start request; a rising edge starts the command.
- sentDat  out  8  byte for the transceiver to send.
- nRxTx  out  1  1 = device transmitting, 0 = idle/receive.
- transTrig  out  1  one-cycle pulse: send sentDat.
- ByteTransDone  in  1  transceiver status; idles high, low while busy; its rising edge means the byte is complete.
- cmdDone  out  1  one-cycle pulse when the last CRC byte completes.

Behaviour:
- One clock, clk. Reset is asynchronous, active-low (nRst).
- Reset values: sentDat=0x00, nRxTx=0, transTrig=0, cmdDone=0, state=IDLE, CRC=0. Edge-detect registers reset to their idle levels: cmdRunTrig low, ByteTransDone high.
- Edge detection:
  - Rising edges of cmdRunTrig and ByteTransDone are detected against a registered copy of each signal.
  - A level held high across several cycles counts as one event.
- States: IDLE, SEND_HDR (TA1, TA2, ES), SEND_DATA, SEND_CRC (low byte, then high byte), TAIL.
- Start (cmdRunTrig edge in IDLE or TAIL):
  - Latch TA1, TA2, ES and Scratchpad; later input changes have no effect.
  - Set offset = TA1[2:0].
  - Initialise CRC = 0x0000, then fold in command byte 0xAA.
  - Next cycle: sentDat=TA1, nRxTx=1, transTrig=1 for exactly one cycle.
- Byte advance:
  - On each ByteTransDone rising edge, fold the byte just sent into the CRC (header and data bytes only).
  - Next cycle: load the next byte into sentDat and pulse transTrig.
  - sentDat holds its value between pulses.
- Byte order:
  - TA1, TA2, ES.
  - Scratchpad bytes offset..7, i.e. 8 - offset bytes.
  - ~CRC[7:0], then ~CRC[15:8].
- CRC16:
  - Polynomial x^16+x^15+x^2+1.
  - Bits processed LSB-first: reflected form, XOR 0xA001 when (crc[0]^bit) is 1.
  - Initial value 0.
  - Covers 0xAA, TA1, TA2, ES and all transmitted data bytes.
- Total bytes before cmdDone = 13 - offset (13 when offset 0, 6 when offset 7).
- After the second CRC byte's done edge:
  - cmdDone pulses for one cycle.
  - Enter TAIL with nRxTx=1.
  - Every further done edge sends sentDat=0xFF with a transTrig pulse.
- TAIL is left only by reset (to IDLE) or by a cmdRunTrig edge (restart).
- cmdRunTrig edges during SEND_HDR, SEND_DATA or SEND_CRC are ignored.
- ByteTransDone edges in IDLE are ignored.
- Reset mid-command: all outputs return to reset values immediately; no cmdDone pulse.
- At most one transTrig pulse per done edge; never two within 2 cycles.

Decomposition:
- Package ds2431_pkg:
  - CMD_READ_SCRATCHPAD=8'hAA, CRC16_POLY_REFL=16'hA001, ROW_BYTES=8, FILL_BYTE=8'hFF.
  - State enum for IDLE/SEND_HDR/SEND_DATA/SEND_CRC/TAIL.
- Sub-module ds2431_crc16_byte: combinational; (crc_in[15:0], data[7:0]) -> crc_out[15:0], 8 unrolled reflected steps. Reused by the write-scratchpad block.

Test Plan:
- Reset then idle: nRst=0 for 10 cycles -> sentDat=0, nRxTx=0, transTrig=0, cmdDone=0. Toggling ByteTransDone produces no transTrig.
- Full row:
  - Stimulus: TA1=0x20, TA2=0x00, ES=0x07, Scratchpad=64'ha005_160b_a6aa_e756, cmdRunTrig high 2 cycles, 13 done edges.
  - Required: sentDat sequence 20,00,07,56,E7,AA,A6,0B,16,05,A0, then ~CRC low/high.
  - Both CRC bytes match a reference CRC16 model over AA,20,00,07 and the data bytes.
  - cmdDone pulses once after the 13th done edge.
- Second command: TA1=0x28, Scratchpad=64'h2174_083a_9497_987b, ES=0x07.
  - Sequence 28,00,07,7B,98,97,94,3A,08,74,21, then CRC.
  - New inputs are latched at the trigger.
- Partial row plus tail:
  - Stimulus: after a reset pulse, TA1=0x23, TA2=0x0A, 14 done edges.
  - Required: 23,0A,07,94,3A,08,74,21, then 2 CRC bytes; cmdDone after byte 10; bytes 11-14 are 0xFF.
- Trigger hold and ignore:
  - cmdRunTrig held high 5 cycles -> exactly one start.
  - cmdRunTrig edge during SEND_DATA -> sequence unchanged.
- Reset mid-stream: assert nRst during byte 5 -> outputs return to reset values at once, no cmdDone. A later trigger restarts cleanly from TA1.

Source files
------------

// File: rtl/ds2431_pkg.sv
// rtl/ds2431_pkg.sv - shared constants and state type for the DS2431 command responders
//
// Contents:
//   CMD_READ_SCRATCHPAD  function command byte, folded into the CRC first
//   CRC16_POLY_REFL      reflected form of x^16+x^15+x^2+1
//   ROW_BYTES            bytes per scratchpad row
//   FILL_BYTE            value sent after the CRC bytes
//   rs_state_t           read-scratchpad sequencer states
package ds2431_pkg;

    localparam logic [7:0]  CMD_READ_SCRATCHPAD = 8'hAA;
    localparam logic [15:0] CRC16_POLY_REFL     = 16'hA001;
    localparam int          ROW_BYTES           = 8;
    localparam logic [7:0]  FILL_BYTE           = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        SEND_HDR,
        SEND_DATA,
        SEND_CRC,
        TAIL
    } rs_state_t;

endpackage

// File: rtl/ds2431_crc16_byte.sv
// rtl/ds2431_crc16_byte.sv - combinational one-byte update of the 1-Wire CRC16
//
// Ports:
//   crc_in   [15:0]  running CRC before this byte
//   data     [7:0]   byte to fold in, consumed LSB first
//   crc_out  [15:0]  running CRC after this byte
module ds2431_crc16_byte
    import ds2431_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC16_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/ds2431_read_scratchpad.sv
// rtl/ds2431_read_scratchpad.sv - Read Scratchpad (0xAA) byte sequencer for the virtual DS2431
//
// Ports:
//   clk, nRst         clock, asynchronous active-low reset
//   Scratchpad [63:0] scratchpad row, byte n at [8n+7:8n]
//   TA1, TA2, ES      target address low/high and ending-address/status
//   cmdRunTrig        rising edge starts the command (from IDLE or TAIL)
//   sentDat [7:0]     byte offered to the transceiver
//   nRxTx             1 while the device is the transmitter
//   transTrig         one-cycle pulse: transmit sentDat
//   ByteTransDone     transceiver idle level; rising edge = byte finished
//   cmdDone           one-cycle pulse after the second CRC byte finishes
module ds2431_read_scratchpad
    import ds2431_pkg::*;
(
    input  logic        clk,
    input  logic        nRst,
    input  logic [63:0] Scratchpad,
    input  logic [7:0]  TA1,
    input  logic [7:0]  TA2,
    input  logic [7:0]  ES,
    input  logic        cmdRunTrig,
    output logic [7:0]  sentDat,
    output logic        nRxTx,
    output logic        transTrig,
    input  logic        ByteTransDone,
    output logic        cmdDone
);

    rs_state_t   state;
    logic        trig_q;
    logic        done_q;
    logic [7:0]  ta2_q;
    logic [7:0]  es_q;
    logic [63:0] pad_q;
    logic [2:0]  offset;
    logic [2:0]  idx;      // header position in SEND_HDR, row byte in SEND_DATA
    logic        crc_hi;
    logic [15:0] crc;
    logic [15:0] crc_cmd;
    logic [15:0] crc_sent;
    logic [2:0]  idx_nxt;
    logic        trig_rise;
    logic        done_rise;

    assign trig_rise = cmdRunTrig & ~trig_q;
    assign done_rise = ByteTransDone & ~done_q;
    assign idx_nxt   = idx + 3'd1;

    // CRC seed after the command byte is a constant of the command.
    ds2431_crc16_byte u_crc_cmd (
        .crc_in  (16'h0000),
        .data    (CMD_READ_SCRATCHPAD),
        .crc_out (crc_cmd)
    );

    // Folds whatever byte has just been completed on the wire.
    ds2431_crc16_byte u_crc_sent (
        .crc_in  (crc),
        .data    (sentDat),
        .crc_out (crc_sent)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state     <= IDLE;
            trig_q    <= 1'b0;
            done_q    <= 1'b1;
            ta2_q     <= 8'h00;
            es_q      <= 8'h00;
            pad_q     <= 64'h0;
            offset    <= 3'd0;
            idx       <= 3'd0;
            crc_hi    <= 1'b0;
            crc       <= 16'h0000;
            sentDat   <= 8'h00;
            nRxTx     <= 1'b0;
            transTrig <= 1'b0;
            cmdDone   <= 1'b0;
        end else begin
            trig_q    <= cmdRunTrig;
            done_q    <= ByteTransDone;
            transTrig <= 1'b0;
            cmdDone   <= 1'b0;

            if (trig_rise && (state == IDLE || state == TAIL)) begin
                ta2_q     <= TA2;
                es_q      <= ES;
                pad_q     <= Scratchpad;
                offset    <= TA1[2:0];
                idx       <= 3'd0;
                crc_hi    <= 1'b0;
                crc       <= crc_cmd;
                sentDat   <= TA1;
                nRxTx     <= 1'b1;
                transTrig <= 1'b1;
                state     <= SEND_HDR;
            end else if (done_rise) begin
                case (state)
                    SEND_HDR: begin
                        crc       <= crc_sent;
                        transTrig <= 1'b1;
                        if (idx == 3'd0) begin
                            sentDat <= ta2_q;
                            idx     <= idx_nxt;
                        end else if (idx == 3'd1) begin
                            sentDat <= es_q;
                            idx     <= idx_nxt;
                        end else begin
                            sentDat <= pad_q[{offset, 3'b000} +: 8];
                            idx     <= offset;
                            state   <= SEND_DATA;
                        end
                    end
                    SEND_DATA: begin
                        crc       <= crc_sent;
                        transTrig <= 1'b1;
                        if (idx == 3'(ROW_BYTES - 1)) begin
                            // Last row byte is folded this cycle, so use the
                            // freshly updated value for the first CRC byte.
                            sentDat <= ~crc_sent[7:0];
                            state   <= SEND_CRC;
                        end else begin
                            sentDat <= pad_q[{idx_nxt, 3'b000} +: 8];
                            idx     <= idx_nxt;
                        end
                    end
                    SEND_CRC: begin
                        if (!crc_hi) begin
                            sentDat   <= ~crc[15:8];
                            crc_hi    <= 1'b1;
                            transTrig <= 1'b1;
                        end else begin
                            cmdDone <= 1'b1;
                            state   <= TAIL;
                        end
                    end
                    TAIL: begin
                        sentDat   <= FILL_BYTE;
                        transTrig <= 1'b1;
                    end
                    default: begin
                        // IDLE: completion edges are not ours to answer
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ds2431_read_scratchpad.sv
// tb/tb_ds2431_read_scratchpad.sv - self-checking bench for ds2431_read_scratchpad
module tb_ds2431_read_scratchpad;

    logic        clk = 1'b0;
    logic        nRst;
    logic [63:0] Scratchpad;
    logic [7:0]  TA1, TA2, ES;
    logic        cmdRunTrig;
    logic [7:0]  sentDat;
    logic        nRxTx;
    logic        transTrig;
    logic        ByteTransDone;
    logic        cmdDone;

    always #10 clk = ~clk;

    ds2431_read_scratchpad dut (
        .clk           (clk),
        .nRst          (nRst),
        .Scratchpad    (Scratchpad),
        .TA1           (TA1),
        .TA2           (TA2),
        .ES            (ES),
        .cmdRunTrig    (cmdRunTrig),
        .sentDat       (sentDat),
        .nRxTx         (nRxTx),
        .transTrig     (transTrig),
        .ByteTransDone (ByteTransDone),
        .cmdDone       (cmdDone)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         last_trig_cyc = -100;
    int         done_pulses = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    // Records every byte the DUT hands to the transceiver.
    always @(negedge clk) begin
        cyc++;
        if (cmdDone) done_pulses++;
        if (transTrig) begin
            got_q.push_back(sentDat);
            n_cmp++;
            if (cyc - last_trig_cyc <= 2) begin
                n_bad++;
                $display("FAIL trig_spacing: got %0d cycles apart, required more than 2", cyc - last_trig_cyc);
            end
            last_trig_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc_upd(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
            else             c = c >> 1;
        end
        return c;
    endfunction

    // Reference: byte list on the wire, CRC over the command byte and all of it.
    task automatic build_exp(input logic [7:0] ta1, input logic [7:0] ta2,
                             input logic [7:0] es, input logic [63:0] pad);
        logic [15:0] c;
        exp_q.delete();
        exp_q.push_back(ta1);
        exp_q.push_back(ta2);
        exp_q.push_back(es);
        for (int i = int'(ta1[2:0]); i < 8; i++) exp_q.push_back(pad[8*i +: 8]);
        c = crc_upd(16'h0000, 8'hAA);
        foreach (exp_q[i]) c = crc_upd(c, exp_q[i]);
        exp_q.push_back(~c[7:0]);
        exp_q.push_back(~c[15:8]);
    endtask

    task automatic done_edge();
        ByteTransDone = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ByteTransDone = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_byte(input int k, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (got_q.size() > k) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_cmd(input logic [7:0] ta1, input logic [7:0] ta2, input logic [7:0] es,
                           input logic [63:0] pad, input int hold, input int n_tail,
                           input int inj_at, input string tag);
        bit          ok;
        logic [15:0] res;
        build_exp(ta1, ta2, es, pad);
        got_q.delete();
        done_pulses = 0;
        TA1 = ta1; TA2 = ta2; ES = es; Scratchpad = pad;
        cmdRunTrig = 1'b1;
        @(negedge clk);
        check({tag, "_start_trig"}, 64'(transTrig), 64'd1);
        check({tag, "_start_nrxtx"}, 64'(nRxTx), 64'd1);
        for (int i = 1; i < hold; i++) @(negedge clk);
        cmdRunTrig = 1'b0;
        // Inputs are latched at the trigger, so disturbing them must not matter.
        TA1 = 8'($urandom); TA2 = 8'($urandom); ES = 8'($urandom);
        Scratchpad = {$urandom, $urandom};
        for (int k = 0; k < exp_q.size(); k++) begin
            wait_byte(k, ok);
            if (!ok) begin
                n_cmp++; n_bad++;
                $display("FAIL %s_timeout: got %0d bytes required %0d", tag, got_q.size(), exp_q.size());
                break;
            end
            if (k == inj_at) begin
                cmdRunTrig = 1'b1;
                @(negedge clk);
                cmdRunTrig = 1'b0;
            end
            done_edge();
        end
        repeat (3) @(negedge clk);
        check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        foreach (exp_q[k]) begin
            if (k < got_q.size()) check($sformatf("%s_byte%0d", tag, k), 64'(got_q[k]), 64'(exp_q[k]));
        end
        res = crc_upd(16'h0000, 8'hAA);
        foreach (got_q[k]) res = crc_upd(res, got_q[k]);
        check({tag, "_crc_residue"}, 64'(res), 64'hB001);
        check({tag, "_cmddone"}, 64'(done_pulses), 64'd1);
        check({tag, "_tail_nrxtx"}, 64'(nRxTx), 64'd1);
        for (int t = 0; t < n_tail; t++) begin
            done_edge();
            wait_byte(exp_q.size() + t, ok);
            if (!ok) begin
                n_cmp++; n_bad++;
                $display("FAIL %s_tail_timeout: got %0d bytes required %0d", tag, got_q.size(), exp_q.size() + t + 1);
                break;
            end
            check($sformatf("%s_tail%0d", tag, t), 64'(got_q[exp_q.size() + t]), 64'hFF);
        end
        repeat (2) @(negedge clk);
        check({tag, "_cmddone_once"}, 64'(done_pulses), 64'd1);
    endtask

    typedef struct {
        logic [7:0]  ta1, ta2, es;
        logic [63:0] pad;
        int          hold, n_tail, inj_at;
        bit          rst_before;
        int          exp_len;
        logic [7:0]  exp_b3;
    } vec_t;

    vec_t vecs[6];

    task automatic reset_pulse();
        nRst = 1'b0;
        repeat (2) @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bit ok;

        vecs[0] = '{8'h20, 8'h00, 8'h07, 64'ha005_160b_a6aa_e756, 2, 0, -1, 1'b0, 13, 8'h56};
        vecs[1] = '{8'h28, 8'h00, 8'h07, 64'h2174_083a_9497_987b, 2, 0, -1, 1'b0, 13, 8'h7B};
        vecs[2] = '{8'h23, 8'h0A, 8'h07, 64'h2174_083a_9497_987b, 1, 4, -1, 1'b1, 10, 8'h94};
        vecs[3] = '{8'h25, 8'h11, 8'h3C, 64'h0123_4567_89ab_cdef, 5, 1, -1, 1'b0,  8, 8'h45};
        vecs[4] = '{8'h00, 8'h55, 8'h1F, 64'hdead_beef_cafe_f00d, 1, 0,  5, 1'b0, 13, 8'h0D};
        vecs[5] = '{8'h07, 8'hC3, 8'h87, 64'h5a00_0000_0000_0000, 3, 2, -1, 1'b0,  6, 8'h5A};

        nRst = 1'b0; cmdRunTrig = 1'b0; ByteTransDone = 1'b1;
        TA1 = 8'h00; TA2 = 8'h00; ES = 8'h00; Scratchpad = 64'h0;
        repeat (10) @(negedge clk);
        check("rst_sentdat", 64'(sentDat), 64'h00);
        check("rst_nrxtx", 64'(nRxTx), 64'd0);
        check("rst_transtrig", 64'(transTrig), 64'd0);
        check("rst_cmddone", 64'(cmdDone), 64'd0);
        nRst = 1'b1;
        @(negedge clk);
        got_q.delete();
        repeat (3) done_edge();
        check("idle_done_ignored", 64'(got_q.size()), 64'd0);
        check("idle_nrxtx", 64'(nRxTx), 64'd0);

        foreach (vecs[v]) begin
            if (vecs[v].rst_before) reset_pulse();
            run_cmd(vecs[v].ta1, vecs[v].ta2, vecs[v].es, vecs[v].pad,
                    vecs[v].hold, vecs[v].n_tail, vecs[v].inj_at, $sformatf("vec%0d", v));
            check($sformatf("vec%0d_total", v), 64'(got_q.size()), 64'(vecs[v].exp_len + vecs[v].n_tail));
            if (got_q.size() > 3) check($sformatf("vec%0d_first_data", v), 64'(got_q[3]), 64'(vecs[v].exp_b3));
        end

        // Reset while the fifth byte is on the wire.
        build_exp(8'h20, 8'h00, 8'h07, 64'ha005_160b_a6aa_e756);
        got_q.delete();
        done_pulses = 0;
        TA1 = 8'h20; TA2 = 8'h00; ES = 8'h07; Scratchpad = 64'ha005_160b_a6aa_e756;
        cmdRunTrig = 1'b1;
        @(negedge clk);
        cmdRunTrig = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_byte(k, ok);
            done_edge();
        end
        wait_byte(4, ok);
        check("midrst_reached_byte5", 64'(ok), 64'd1);
        #3 nRst = 1'b0;
        #1;
        check("midrst_sentdat", 64'(sentDat), 64'h00);
        check("midrst_nrxtx", 64'(nRxTx), 64'd0);
        check("midrst_transtrig", 64'(transTrig), 64'd0);
        check("midrst_cmddone", 64'(cmdDone), 64'd0);
        repeat (3) @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);
        check("midrst_no_cmddone", 64'(done_pulses), 64'd0);
        run_cmd(8'h20, 8'h00, 8'h07, 64'ha005_160b_a6aa_e756, 1, 0, -1, "restart");

        // Randomized commands against the reference model.
        for (int r = 0; r < 6; r++) begin
            run_cmd(8'($urandom), 8'($urandom), 8'($urandom), {$urandom, $urandom},
                    int'($urandom_range(1, 3)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 20)), $sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, required finish before time limit");
        $fatal(1);
    end

endmodule
